fpu_sched: RTL and testbench

FPU_SCHED -- requirements
Module: fpu_sched

---
 rtl/fpu_sched_pkg.sv | 22 ++
 rtl/rr_arb2.sv | 21 ++
 rtl/fpu_sched.sv | 134 +++++++++++++
 tb/tb_fpu_sched.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_sched_pkg.sv
// Shared types and widths for the FPU request scheduler.
package fpu_sched_pkg;

  // Operand format: sign | exponent | mantissa
  localparam int EXP_W    = 6;
  localparam int MANT_W   = 25;
  localparam int FLOAT_W  = 1 + EXP_W + MANT_W;
  localparam int STATUS_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // One-hot requester mask from a requester index
  function automatic logic [1:0] req_mask(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin grant; purely combinational.
module rr_arb2 (
  input  logic [1:0] req_valid,
  input  logic       last,
  output logic       grant_valid,
  output logic       grant
);

  // On a tie, favour the requester that was not served last
  always_comb begin
    grant_valid = |req_valid;
    grant       = 1'b0;
    case (req_valid)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last;
      default: grant = 1'b0;
    endcase
  end

endmodule

// File: rtl/fpu_sched.sv
// Schedules two requesters onto one shared multi-cycle FPU, one
// operation in flight at a time, with round-robin arbitration.
//
// state | meaning
// IDLE  | waiting for a request; grant is offered on req_ready
// ISSUE | restart pulse to the FPU, latency counter loaded
// WAIT  | counting down FPU latency; result captured at zero
// RESP  | result presented to the granted requester until consumed
module fpu_sched
  import fpu_sched_pkg::*;
#(
  parameter int FPU_LAT = 8
) (
  input  logic                clock100KHz,
  input  logic                reset,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [FLOAT_W-1:0]  req0_a,
  input  logic [FLOAT_W-1:0]  req0_b,
  input  logic [FLOAT_W-1:0]  req1_a,
  input  logic [FLOAT_W-1:0]  req1_b,
  output logic [1:0]          rsp_valid,
  input  logic [1:0]          rsp_ready,
  output logic [FLOAT_W-1:0]  rsp_data,
  output logic [STATUS_W-1:0] rsp_status,
  output logic [FLOAT_W-1:0]  fpu_op_a,
  output logic [FLOAT_W-1:0]  fpu_op_b,
  output logic                fpu_reset,
  input  logic [FLOAT_W-1:0]  fpu_data,
  input  logic [STATUS_W-1:0] fpu_status,
  output logic                busy
);

  localparam int CNT_W = $clog2(FPU_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FPU_LAT - 1);

  state_t           state, state_next;
  logic             last;
  logic             cur;
  logic             grant_valid;
  logic             grant;
  logic             accept;
  logic             wait_done;
  logic [CNT_W-1:0] cnt;

  rr_arb2 u_arb (
    .req_valid   (req_valid),
    .last        (last),
    .grant_valid (grant_valid),
    .grant       (grant)
  );

  // State register
  always_ff @(posedge clock100KHz or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state and handshake outputs; reset masks the grant and holds
  // the FPU in restart for as long as it is asserted
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    req_ready  = 2'b00;
    rsp_valid  = 2'b00;
    busy       = 1'b1;
    fpu_reset  = reset;
    wait_done  = 1'b0;
    case (state)
      IDLE: begin
        busy   = 1'b0;
        accept = grant_valid && !reset;
        if (accept) begin
          req_ready  = req_mask(grant);
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        fpu_reset  = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        if (cnt == '0) begin
          wait_done  = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        rsp_valid = req_mask(cur);
        if (rsp_ready[cur]) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Latency down-counter; holds at zero so it can never wrap
  always_ff @(posedge clock100KHz or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (state == ISSUE) begin
      cnt <= CNT_LOAD;
    end else if (state == WAIT && cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // Operand latch and grant bookkeeping on accept; operands persist
  // until the next accept so the FPU inputs never glitch
  always_ff @(posedge clock100KHz or posedge reset) begin
    if (reset) begin
      fpu_op_a <= '0;
      fpu_op_b <= '0;
      cur      <= 1'b0;
      last     <= 1'b1;
    end else if (accept) begin
      fpu_op_a <= grant ? req1_a : req0_a;
      fpu_op_b <= grant ? req1_b : req0_b;
      cur      <= grant;
      last     <= grant;
    end
  end

  // Result capture at the end of the latency window
  always_ff @(posedge clock100KHz or posedge reset) begin
    if (reset) begin
      rsp_data   <= '0;
      rsp_status <= '0;
    end else if (wait_done) begin
      rsp_data   <= fpu_data;
      rsp_status <= fpu_status;
    end
  end

endmodule

// File: tb/tb_fpu_sched.sv
// Scoreboard bench for fpu_sched: directed scenarios plus a random phase,
// with an FPU stub whose output is only valid FPU_LAT cycles after restart.
module tb_fpu_sched;

  localparam int L   = 8;
  localparam int INF = 1 << 30;

  logic        clock100KHz = 1'b0;
  logic        reset;
  logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [31:0] rsp_data, fpu_op_a, fpu_op_b, fpu_data;
  logic [3:0]  rsp_status, fpu_status;
  logic        fpu_reset, busy;

  fpu_sched #(.FPU_LAT(L)) dut (
    .clock100KHz (clock100KHz),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req0_a      (req0_a),
    .req0_b      (req0_b),
    .req1_a      (req1_a),
    .req1_b      (req1_b),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_status  (rsp_status),
    .fpu_op_a    (fpu_op_a),
    .fpu_op_b    (fpu_op_b),
    .fpu_reset   (fpu_reset),
    .fpu_data    (fpu_data),
    .fpu_status  (fpu_status),
    .busy        (busy)
  );

  always #5 clock100KHz = ~clock100KHz;

  int cycle = 0;
  always @(posedge clock100KHz) cycle <= cycle + 1;

  // Reference FPU function
  function automatic logic [31:0] ref_data(input logic [31:0] a, b, input bit fixed);
    if (fixed) return 32'h15A0_0000;
    return {a[31:16] ^ b[15:0], a[15:0] + b[31:16]};
  endfunction
  function automatic logic [3:0] ref_status(input logic [31:0] a, b, input bit fixed);
    if (fixed) return 4'b0001;
    return a[3:0] ^ b[7:4] ^ 4'h5;
  endfunction

  // FPU stub: garbage until L cycles after the restart pulse falls
  int stub_cnt = 0;
  bit stub_fixed = 0;
  always @(posedge clock100KHz) begin
    if (fpu_reset)          stub_cnt <= 0;
    else if (stub_cnt < 255) stub_cnt <= stub_cnt + 1;
  end
  always_comb begin
    fpu_data   = 32'hDEAD_0000 ^ 32'(stub_cnt);
    fpu_status = 4'hA ^ 4'(stub_cnt);
    if (stub_cnt >= L - 1) begin
      fpu_data   = ref_data(fpu_op_a, fpu_op_b, stub_fixed);
      fpu_status = ref_status(fpu_op_a, fpu_op_b, stub_fixed);
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired (cycle %0d)", name, cycle);
  endtask

  // Scoreboard and reference-model state
  typedef struct {
    int          id;
    logic [31:0] data;
    logic [3:0]  st;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  int          acc_log[$];
  exp_t        e;
  int          idle_from = 0;
  int          acc_last  = 0;
  int          issue_at  = -1;
  int          op_edge   = 0;
  bit          last_g    = 1'b1;
  bit          op_pend   = 1'b0;
  bit          active    = 1'b0;
  logic [31:0] cur_a = '0, cur_b = '0, nxt_a, nxt_b;
  logic [1:0]  hs_seen = 2'b00;
  logic [1:0]  obs_rdy;
  bit          obs_g;
  bit          rand_en = 0, rsp_rand_en = 0;

  task automatic reset_model();
    sb.delete();
    active    = 0;
    idle_from = 0;
    acc_last  = 0;
    issue_at  = -1;
    last_g    = 1'b1;
    cur_a     = '0;
    cur_b     = '0;
    op_pend   = 0;
    hs_seen   = 2'b00;
  endtask

  // Request-side observer: predicts the grant, checks req_ready, pushes expectations
  initial forever begin
    @(negedge clock100KHz);
    if (!reset) begin
      obs_rdy = 2'b00;
      obs_g   = 1'b0;
      if (cycle >= idle_from && req_valid != 2'b00) begin
        obs_g   = (req_valid == 2'b11) ? !last_g : req_valid[1];
        obs_rdy = obs_g ? 2'b10 : 2'b01;
      end
      chk("req_ready", req_ready, obs_rdy);
      hs_seen = req_valid & req_ready;
      if (hs_seen != 2'b00) acc_log.push_back(hs_seen[1] ? 1 : 0);
      if (obs_rdy != 2'b00) begin
        e.id   = obs_g;
        nxt_a  = obs_g ? req1_a : req0_a;
        nxt_b  = obs_g ? req1_b : req0_b;
        e.data = ref_data(nxt_a, nxt_b, stub_fixed);
        e.st   = ref_status(nxt_a, nxt_b, stub_fixed);
        e.acc  = cycle + 1;
        sb.push_back(e);
        last_g    = obs_g;
        idle_from = INF;
        acc_last  = cycle + 1;
        issue_at  = cycle + 1;
        op_edge   = cycle + 1;
        op_pend   = 1;
      end
    end
  end

  // Response-side monitor: FPU interface, busy, and response checks
  exp_t m;
  initial forever begin
    @(negedge clock100KHz);
    if (!reset) begin
      if (op_pend && cycle >= op_edge) begin
        cur_a   = nxt_a;
        cur_b   = nxt_b;
        op_pend = 0;
      end
      chk("fpu_op_a", fpu_op_a, cur_a);
      chk("fpu_op_b", fpu_op_b, cur_b);
      chk("fpu_reset", fpu_reset, cycle == issue_at);
      chk("busy", busy, (cycle >= acc_last) && (cycle < idle_from));
      if (rsp_valid != 2'b00) begin
        if (!active) begin
          if (sb.size() == 0) begin
            chk("rsp_unexpected", rsp_valid, 2'b00);
          end else begin
            m = sb.pop_front();
            active = 1;
            chk("rsp_latency", cycle, m.acc + L + 1);
          end
        end
        if (active) begin
          chk("rsp_valid", rsp_valid, m.id ? 2'b10 : 2'b01);
          chk("rsp_data", rsp_data, m.data);
          chk("rsp_status", rsp_status, m.st);
          if ((rsp_valid & rsp_ready) != 2'b00) begin
            active    = 0;
            idle_from = cycle + 1;
          end
        end
      end else begin
        if (active) begin
          chk("rsp_dropped", rsp_valid, m.id ? 2'b10 : 2'b01);
          active    = 0;
          idle_from = cycle + 1;
        end else if (sb.size() > 0 && cycle > sb[0].acc + L + 1) begin
          m = sb.pop_front();
          chk("rsp_late", rsp_valid, m.id ? 2'b10 : 2'b01);
          idle_from = cycle + 1;
        end
      end
    end
  end

  // Random requesters and consumer
  initial forever begin
    @(posedge clock100KHz);
    #1;
    if (rand_en && !reset) begin
      for (int i = 0; i < 2; i++) begin
        if (hs_seen[i] || !req_valid[i]) begin
          req_valid[i] = ($urandom_range(0, 2) == 0);
          if (i == 0) begin req0_a = $urandom; req0_b = $urandom; end
          else        begin req1_a = $urandom; req1_b = $urandom; end
        end
      end
    end
    if (rsp_rand_en) rsp_ready = 2'($urandom_range(0, 3));
  end

  task automatic tick();
    @(posedge clock100KHz);
    #1;
  endtask

  task automatic wait_drain(input int limit, input string name);
    int n = 0;
    while (!(sb.size() == 0 && !active && cycle >= idle_from) && n < limit) begin
      @(negedge clock100KHz);
      n++;
    end
    if (n >= limit) fail_now(name);
  endtask

  logic [31:0] orig_a, orig_b;
  int          ord[4] = '{0, 1, 0, 1};
  int          n;

  initial begin
    reset     = 1'b1;
    req_valid = 2'b11;
    rsp_ready = 2'b00;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    repeat (3) @(posedge clock100KHz);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 2'b00);
    chk("rst_req_ready", req_ready, 2'b00);
    chk("rst_fpu_reset", fpu_reset, 1);
    chk("rst_op_a", fpu_op_a, 0);
    chk("rst_op_b", fpu_op_b, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_status", rsp_status, 0);
    req_valid = 2'b00;
    #1 reset = 1'b0;

    // Single request from requester 0 with a fixed stub result
    rsp_ready  = 2'b11;
    stub_fixed = 1;
    tick();
    req0_a = 32'h1500_0000; req0_b = 32'h1540_0000; req_valid = 2'b01;
    #1 chk("rdy_same_cycle", req_ready, 2'b01);
    tick();
    req_valid = 2'b00; req0_a = $urandom; req0_b = $urandom;
    @(negedge clock100KHz);
    chk("op_a_latched", fpu_op_a, 32'h1500_0000);
    chk("op_b_latched", fpu_op_b, 32'h1540_0000);
    wait_drain(L + 10, "single_drain");
    stub_fixed = 0;

    // Response held for 5 cycles; other requester and other rsp_ready bit active
    rsp_ready = 2'b00;
    tick();
    req0_a = $urandom; req0_b = $urandom; req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    n = 0;
    while (rsp_valid[0] !== 1'b1 && n < 40) begin @(negedge clock100KHz); n++; end
    if (n >= 40) fail_now("hold_no_rsp");
    tick();
    req_valid = 2'b10; req1_a = $urandom; req1_b = $urandom; rsp_ready = 2'b10;
    repeat (5) begin
      @(negedge clock100KHz);
      chk("hold_valid", rsp_valid, 2'b01);
      chk("hold_ready", req_ready, 2'b00);
      chk("hold_busy", busy, 1);
      tick();
    end
    req_valid = 2'b00; rsp_ready = 2'b11;
    wait_drain(20, "hold_drain");

    // Requester 1 changes operands while its operation is in flight
    tick();
    orig_a = $urandom; orig_b = $urandom;
    req1_a = orig_a; req1_b = orig_b; req_valid = 2'b10;
    tick();
    req_valid = 2'b00;
    repeat (4) begin
      req1_a = $urandom; req1_b = $urandom;
      @(negedge clock100KHz);
      chk("inflight_op_a", fpu_op_a, orig_a);
      chk("inflight_op_b", fpu_op_b, orig_b);
      tick();
    end
    wait_drain(L + 10, "inflight_drain");

    // Reset during WAIT discards the operation
    tick();
    req0_a = $urandom; req0_b = $urandom; req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    repeat (4) tick();
    reset = 1'b1;
    req_valid = 2'b11;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_rsp_valid", rsp_valid, 2'b00);
    chk("midrst_fpu_reset", fpu_reset, 1);
    chk("midrst_req_ready", req_ready, 2'b00);
    reset_model();
    req_valid = 2'b00;
    repeat (2) @(posedge clock100KHz);
    #2 reset = 1'b0;
    repeat (L + 6) begin
      @(negedge clock100KHz);
      chk("no_late_rsp", rsp_valid, 2'b00);
    end

    // Both requesters valid from reset: strict alternation starting at 0
    @(posedge clock100KHz);
    #2 reset = 1'b1;
    req0_a = 32'h3F00_0011; req0_b = 32'h0123_4567;
    req1_a = 32'hC1A0_0022; req1_b = 32'h89AB_CDEF;
    req_valid = 2'b11; rsp_ready = 2'b11;
    reset_model();
    acc_log.delete();
    repeat (2) @(posedge clock100KHz);
    #2 reset = 1'b0;
    n = 0;
    while (acc_log.size() < 4 && n < 200) begin @(negedge clock100KHz); n++; end
    if (n >= 200) fail_now("rr_accepts");
    tick();
    req_valid = 2'b00;
    for (int k = 0; k < 4; k++) begin
      if (k < acc_log.size()) chk($sformatf("rr_order_%0d", k), acc_log[k], ord[k]);
      else fail_now($sformatf("rr_order_%0d", k));
    end
    wait_drain(L + 10, "rr_drain");

    // Random traffic
    rand_en = 1; rsp_rand_en = 1;
    repeat (1500) @(posedge clock100KHz);
    rand_en = 0; rsp_rand_en = 0;
    #1;
    req_valid = 2'b00; rsp_ready = 2'b11;
    wait_drain(100, "random_drain");
    chk("sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
